// File: rtl/excite_pulse_gen_pkg.sv
// Shared constants and state encoding for the excitation burst generator.
package excite_pulse_gen_pkg;

    localparam int unsigned DEFAULT_CW        = 16;
    localparam int unsigned DEFAULT_NW        = 8;
    localparam int unsigned DEFAULT_HALF_1MHZ = 50;

    // Burst FSM state encoding, kept as plain constants for legacy compatibility.
    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] pulseState_t;

    localparam pulseState_t IDLE  = 3'd0;
    localparam pulseState_t POS   = 3'd1;
    localparam pulseState_t DEAD1 = 3'd2;
    localparam pulseState_t NEG   = 3'd3;
    localparam pulseState_t DEAD2 = 3'd4;
    localparam pulseState_t FAULT = 3'd5;

endpackage

// File: rtl/excite_pulse_gen_phase_timer.sv
// Loadable down-counter that times one burst phase; expires when it reaches 1.
module phase_timer #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] loadVal,
    output logic          expire_c
);

    logic [CW-1:0] count;

    // Load with a zero-to-one clamp, otherwise count down and park at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= (loadVal == '0) ? CW'(1) : loadVal;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expire_c = (count == CW'(1));

endmodule

// File: rtl/excite_pulse_gen.sv
// Gated bipolar excitation burst generator driving the transducer bridge triggers.
module excite_pulse_gen
    import excite_pulse_gen_pkg::*;
#(
    parameter int unsigned     CW        = DEFAULT_CW,
    parameter int unsigned     NW        = DEFAULT_NW,
    parameter logic [CW-1:0]   HALF_1MHZ = CW'(DEFAULT_HALF_1MHZ)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] half_period,
    input  logic [CW-1:0] dead_time,
    input  logic [NW-1:0] cycles,
    input  logic          bipolar,
    input  logic          protect_en,
    input  logic          fault_clr,
    output logic          triggerP,
    output logic          triggerN,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic          freq_flag
);

    pulseState_t   state;
    pulseState_t   stateNext;
    logic [NW-1:0] cycCnt;
    logic [NW-1:0] cycCntNext;
    logic [CW-1:0] halfLat;
    logic [CW-1:0] deadLat;
    logic          bipolarLat;
    logic          accept;
    logic          doneNext;
    logic          timerLoad;
    logic [CW-1:0] timerLoadVal;
    logic          timerExpire_c;
    logic          triggerPReg;
    logic          triggerNReg;

    phase_timer #(.CW(CW)) u_phaseTimer (
        .clk      (clk),
        .reset    (reset),
        .load     (timerLoad),
        .loadVal  (timerLoadVal),
        .expire_c (timerExpire_c)
    );

    // Next-state logic; protection overrides everything outside FAULT.
    always_comb begin
        stateNext    = state;
        cycCntNext   = cycCnt;
        accept       = 1'b0;
        doneNext     = 1'b0;
        timerLoad    = 1'b0;
        timerLoadVal = halfLat;

        if (state != FAULT && protect_en) begin
            stateNext = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (start && cycles != '0) begin
                        accept       = 1'b1;
                        stateNext    = POS;
                        timerLoad    = 1'b1;
                        timerLoadVal = half_period;
                        cycCntNext   = cycles;
                    end
                end
                POS: begin
                    if (timerExpire_c) begin
                        timerLoad    = 1'b1;
                        timerLoadVal = deadLat;
                        stateNext    = bipolarLat ? DEAD1 : DEAD2;
                    end
                end
                DEAD1: begin
                    if (timerExpire_c) begin
                        timerLoad    = 1'b1;
                        timerLoadVal = halfLat;
                        stateNext    = NEG;
                    end
                end
                NEG: begin
                    if (timerExpire_c) begin
                        timerLoad    = 1'b1;
                        timerLoadVal = deadLat;
                        stateNext    = DEAD2;
                    end
                end
                DEAD2: begin
                    if (timerExpire_c) begin
                        cycCntNext = cycCnt - NW'(1);
                        if (cycCnt == NW'(1)) begin
                            stateNext = IDLE;
                            doneNext  = 1'b1;
                        end else begin
                            timerLoad    = 1'b1;
                            timerLoadVal = halfLat;
                            stateNext    = POS;
                        end
                    end
                end
                FAULT: begin
                    if (fault_clr && !protect_en) begin
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // State, latched configuration and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cycCnt      <= '0;
            halfLat     <= '0;
            deadLat     <= '0;
            bipolarLat  <= 1'b0;
            triggerPReg <= 1'b0;
            triggerNReg <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            freq_flag   <= 1'b0;
        end else begin
            state       <= stateNext;
            cycCnt      <= cycCntNext;
            triggerPReg <= (stateNext == POS);
            triggerNReg <= (stateNext == NEG);
            busy        <= (stateNext == POS) || (stateNext == DEAD1) ||
                           (stateNext == NEG) || (stateNext == DEAD2);
            done        <= doneNext;
            fault       <= (stateNext == FAULT);
            if (accept) begin
                halfLat    <= half_period;
                deadLat    <= dead_time;
                bipolarLat <= bipolar;
                freq_flag  <= (half_period >= HALF_1MHZ);
            end
        end
    end

    // Protection cuts the drives combinationally, ahead of the state change.
    assign triggerP = triggerPReg & ~protect_en;
    assign triggerN = triggerNReg & ~protect_en;

endmodule

// File: doc/excite_pulse_gen.md
Name: excite_pulse_gen

Overview:
- Generates the gated bipolar excitation burst on triggerP/triggerN that drives the transducer MOSFET bridge.
- It is the source end of the trigger interface. The protection block consumes triggerP/triggerN and returns protect_en, which this block obeys.
- It also produces freq_flag for the protection block: 1 when the burst frequency is <= 1 MHz.
- Configuration is latched per burst from the control registers. A burst starts on a single-cycle start strobe.

Parameters:
- CW, 16, width of the half_period and dead_time fields and of the phase counter.
- NW, 8, width of the cycle-count field and cycle counter.
- HALF_1MHZ, 16'd50, half-period in clk cycles equal to 1 MHz. freq_flag=1 when half_period >= HALF_1MHZ.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle burst request.
- half_period  in  CW  drive-phase length in cycles; 0 is treated as 1.
- dead_time  in  CW  gap after each drive phase in cycles; 0 is treated as 1.
- cycles  in  NW  number of excitation periods per burst.
- bipolar  in  1  1 = P then N per period; 0 = P only.
- protect_en  in  1  from the protection block; 1 = protect.
- fault_clr  in  1  single-cycle fault acknowledge.
- triggerP  out  1  positive drive.
- triggerN  out  1  negative drive.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at normal burst completion.
- fault  out  1  latched abort indicator.
- freq_flag  out  1  1 = frequency <= 1 MHz, for the protection block.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, state IDLE, all counters 0. Reset mid-burst drops both drives on the next edge.
- States:
  - IDLE, POS, DEAD1, NEG, DEAD2, FAULT.
- Transitions:
  - IDLE: start=1 and cycles!=0 → latch config, load phase counter with H, cycle counter with cycles, go POS. start with cycles=0 is ignored, no done.
  - POS, after H cycles: → DEAD1 if bipolar, else → DEAD2.
  - DEAD1, after D cycles: → NEG.
  - NEG, after H cycles: → DEAD2.
  - DEAD2, after D cycles: decrement the cycle counter. If the count is nonzero → POS; if it was the last period → IDLE with done=1 for one cycle.
- Any state except FAULT: protect_en=1 → FAULT. This takes priority over start and over phase expiry. No done is issued.
- FAULT: fault=1, busy=0. Stay until fault_clr=1 and protect_en=0 in the same cycle, then → IDLE.
- Simultaneous start and protect_en in IDLE → FAULT; the burst is not started.
- start is ignored while busy or in FAULT.
- Drives:
  - triggerP_reg=1 only in POS; triggerN_reg=1 only in NEG. Both are registered.
  - Output gating: triggerP = triggerP_reg & ~protect_en, and likewise triggerN. Protection cutoff is combinational (0 cycles); the state change follows on the next edge.
  - triggerP and triggerN are never 1 together. Every P→N and N→P transition has at least one all-low cycle.
- Latency and length:
  - start sampled at edge k → triggerP high from cycle k+1.
  - busy=1 in every cycle of POS, DEAD1, NEG and DEAD2.
  - Burst length is cycles×(2H+2D) in bipolar mode, or cycles×(H+D) in unipolar mode.
  - done asserts in the cycle after the final dead cycle, with busy=0 in that cycle.
- freq_flag: registered at burst start from the latched H. It holds until the next accepted start. Reset value 0.
- Widths: the phase counter is a CW-bit down-counter that expires at 1, with no wrap. The cycle counter is NW bits; cycles=255 is a legal maximum.
- Config changes mid-burst have no effect; only the values latched at start are used.

Decomposition:
- Package excite_pulse_gen_pkg holds:
  - the state enum (IDLE, POS, DEAD1, NEG, DEAD2, FAULT);
  - the CW and NW defaults;
  - the HALF_1MHZ constant.
- One natural sub-module, phase_timer: a loadable CW-bit down-counter with load, a zero-to-one clamp on the load value, and a one-cycle expire output. The FSM instantiates one phase_timer.

Test Plan:
- Bipolar run: H=3, D=2, cycles=2, start at cycle 0 → P high 1–3, N 6–8, P 11–13, N 16–18, all other cycles low. busy high 1–20, done at 21 only.
- Unipolar run: bipolar=0, H=4, D=1, cycles=3 → P high 1–4, 6–9, 11–14; N never high. done at 16.
- Abort: protect_en=1 at cycle 7 of the bipolar run → triggerN low in cycle 7 (combinational), fault=1 from cycle 8, no done. start is ignored until fault_clr=1 with protect_en=0, then a new start produces a normal burst.
- Boundaries:
  - H=0, D=0, cycles=1 → behaves as H=1, D=1: P at 1, N at 3, done at 5.
  - cycles=0 → no activity.
  - start while busy → no effect on the burst.
- freq_flag: H=50 → 1; H=49 → 0. The value changes only on an accepted start.
- Reset mid-burst (reset=1 at cycle 2) → all outputs 0 from cycle 3, state IDLE. A start at cycle 5 begins a fresh burst with P high at 6.
